// File: rtl/bcd_counter_multi.sv
// Multi-decade packed-BCD up/down counter with clear, clamped parallel load,
// wrap-or-saturate limit handling and a registered carry/borrow pulse.
module bcd_counter_multi #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  carry_out,
  output logic                  at_limit
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count;
  logic [W-1:0] din_clamped;
  logic [W-1:0] count_inc;
  logic [W-1:0] count_dec;
  logic [3:0]   digit;
  logic [3:0]   ld_digit;
  logic         nine_run;
  logic         zero_run;
  logic         all_nine;
  logic         all_zero;

  // Ripple the "all lower digits at 9 / at 0" condition through the decades so
  // the whole carry or borrow chain settles within one cycle.
  always_comb begin
    din_clamped = '0;
    count_inc   = '0;
    count_dec   = '0;
    digit       = '0;
    ld_digit    = '0;
    nine_run    = 1'b1;
    zero_run    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      digit    = count[4*k +: 4];
      ld_digit = din[4*k +: 4];
      din_clamped[4*k +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
      if (nine_run)
        count_inc[4*k +: 4] = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
      else
        count_inc[4*k +: 4] = digit;
      if (zero_run)
        count_dec[4*k +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      else
        count_dec[4*k +: 4] = digit;
      nine_run = nine_run & (digit == 4'd9);
      zero_run = zero_run & (digit == 4'd0);
    end
    all_nine = nine_run;
    all_zero = zero_run;
  end

  assign at_limit = up_dn ? all_nine : all_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= din_clamped;
      end else if (en) begin
        // At the limit the incremented/decremented value is already the wrapped
        // one; saturating mode simply refuses to take it.
        if (!at_limit || WRAP) begin
          count <= up_dn ? count_inc : count_dec;
        end
        carry_out <= at_limit && WRAP;
      end
    end
  end

  assign dout = count;

endmodule
